// File: rtl/mapa_pkg.sv
// Shared map definitions: cell codes, default arena size and write-arbiter FSM states.
package mapa_pkg;

    localparam int MAPA_WIDTH_DEF  = 40;
    localparam int MAPA_HEIGHT_DEF = 30;

    localparam logic [1:0] CELL_EMPTY     = 2'b00;
    localparam logic [1:0] CELL_COBRA     = 2'b01;
    localparam logic [1:0] CELL_FRUTA     = 2'b10;
    localparam logic [1:0] CELL_OBSTACULO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWEEP = 2'd2,
        ST_FLUSH = 2'd3
    } wr_state_t;

endpackage

// File: rtl/mapa_write_arbiter_if.sv
// Producer channels, clear control and map write port of the write arbiter.
interface mapa_write_arbiter_if #(
    parameter int COORD_W    = 10,
    parameter int FIFO_DEPTH = 8
);
    logic               snake_valid, snake_ready;
    logic [COORD_W-1:0] snake_x, snake_y;
    logic [1:0]         snake_data;
    logic               fruta_valid, fruta_ready;
    logic [COORD_W-1:0] fruta_x, fruta_y;
    logic [1:0]         fruta_data;
    logic               obst_valid, obst_ready;
    logic [COORD_W-1:0] obst_x, obst_y;
    logic [1:0]         obst_data;
    logic               clear_start, clear_busy;
    logic               mapa_wready, update_wenable;
    logic [COORD_W-1:0] update_wx, update_wy;
    logic [1:0]         update_wdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic [7:0]         drop_count;

    modport master (
        output snake_valid, snake_x, snake_y, snake_data,
        output fruta_valid, fruta_x, fruta_y, fruta_data,
        output obst_valid, obst_x, obst_y, obst_data,
        output clear_start, mapa_wready,
        input  snake_ready, fruta_ready, obst_ready, clear_busy,
        input  update_wenable, update_wx, update_wy, update_wdata,
        input  fifo_level, drop_count
    );

    modport slave (
        input  snake_valid, snake_x, snake_y, snake_data,
        input  fruta_valid, fruta_x, fruta_y, fruta_data,
        input  obst_valid, obst_x, obst_y, obst_data,
        input  clear_start, mapa_wready,
        output snake_ready, fruta_ready, obst_ready, clear_busy,
        output update_wenable, update_wx, update_wy, update_wdata,
        output fifo_level, drop_count
    );

endinterface

// File: rtl/mapa_wr_fifo.sv
// Synchronous FIFO of packed {x,y,data} map writes.
// Latency: a push is visible at head_dat after the next edge.
// Backpressure: push ignored while full; pop ignored while empty.
module mapa_wr_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_dat,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head_dat,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so level distinguishes full from empty.
    assign level    = wr_ptr - rd_ptr;
    assign full     = level == (AW+1)'(DEPTH);
    assign empty    = level == '0;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/mapa_write_arbiter.sv
// Merges snake/fruit/obstacle cell writes (fixed priority) into one queued map write stream, plus a sequenced full-map clear; MAPA_WR_BORDER_EN makes the clear draw a wall border.
// Latency: request accepted at edge N appears on update_* in cycle N+1 when the queue was empty.
// Backpressure: readys drop while the queue is full or a clear is running; head holds until mapa_wready.
module mapa_write_arbiter
    import mapa_pkg::*;
#(
    parameter int MAPA_WIDTH  = MAPA_WIDTH_DEF,
    parameter int MAPA_HEIGHT = MAPA_HEIGHT_DEF,
    parameter int COORD_W     = 10,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic           clk,
    input  logic           reset,
    mapa_write_arbiter_if.slave bus
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = 2*COORD_W + 2;
    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(MAPA_WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(MAPA_HEIGHT - 1);

    wr_state_t          state_q, state_d;
    logic [COORD_W-1:0] cx_q, cy_q;
    logic [7:0]         drop_q;
    logic               full, empty, push, pop;
    logic [EW-1:0]      push_dat, head_dat;
    logic [LW-1:0]      level;
    logic               accept_en, sweep_push, sweep_last;
    logic               grant_s, grant_f, grant_o, xfer, in_range;
    logic [COORD_W-1:0] req_x, req_y;
    logic [1:0]         req_data, sweep_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.clear_start) state_d = ST_DRAIN;
            ST_DRAIN: if (empty) state_d = ST_SWEEP;
            ST_SWEEP: if (sweep_push && sweep_last) state_d = ST_FLUSH;
            // Leave on the pop that empties the queue so clear_busy falls right after the last write.
            ST_FLUSH: if (empty || (pop && level == LW'(1))) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        accept_en       = reset && (state_q == ST_IDLE) && !full;
        bus.snake_ready = accept_en;
        bus.fruta_ready = accept_en && !bus.snake_valid;
        bus.obst_ready  = accept_en && !bus.snake_valid && !bus.fruta_valid;
        bus.clear_busy  = state_q != ST_IDLE;
        sweep_push      = (state_q == ST_SWEEP) && !full;
    end

    always_comb begin
        grant_s  = bus.snake_valid && bus.snake_ready;
        grant_f  = bus.fruta_valid && bus.fruta_ready;
        grant_o  = bus.obst_valid  && bus.obst_ready;
        xfer     = grant_s || grant_f || grant_o;
        req_x    = bus.obst_x;
        req_y    = bus.obst_y;
        req_data = bus.obst_data;
        if (grant_s) begin
            req_x    = bus.snake_x;
            req_y    = bus.snake_y;
            req_data = bus.snake_data;
        end else if (grant_f) begin
            req_x    = bus.fruta_x;
            req_y    = bus.fruta_y;
            req_data = bus.fruta_data;
        end
        in_range = (req_x < COORD_W'(MAPA_WIDTH)) && (req_y < COORD_W'(MAPA_HEIGHT));
`ifdef MAPA_WR_BORDER_EN
        sweep_data = (cx_q == '0 || cx_q == LAST_X || cy_q == '0 || cy_q == LAST_Y)
                     ? CELL_OBSTACULO : CELL_EMPTY;
`else
        sweep_data = CELL_EMPTY;
`endif
        sweep_last = (cx_q == LAST_X) && (cy_q == LAST_Y);
        push       = sweep_push || (xfer && in_range);
        push_dat   = sweep_push ? {cx_q, cy_q, sweep_data} : {req_x, req_y, req_data};
        pop        = !empty && bus.mapa_wready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (state_q == ST_DRAIN) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (sweep_push) begin
            if (cx_q == LAST_X) begin
                cx_q <= '0;
                cy_q <= cy_q + COORD_W'(1);
            end else begin
                cx_q <= cx_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                 drop_q <= '0;
        else if (xfer && !in_range && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end

    mapa_wr_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    // Stale RAM contents never leak out: the port reads zero whenever the queue is empty.
    assign bus.update_wenable = !empty;
    assign {bus.update_wx, bus.update_wy, bus.update_wdata} = empty ? '0 : head_dat;
    assign bus.fifo_level = level;
    assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_mapa_write_arbiter.sv
// Randomized bench for mapa_write_arbiter against a queue-level model of the write stream.
`timescale 1ns/1ps
module tb_mapa_write_arbiter;
    localparam int W = 40, H = 30, CW = 10, DEPTH = 8;
`ifdef MAPA_WR_BORDER_EN
    localparam int BORDER_EXP = 2*W + 2*(H-2);
`else
    localparam int BORDER_EXP = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mapa_write_arbiter_if #(.COORD_W(CW), .FIFO_DEPTH(DEPTH)) bus();
    mapa_write_arbiter #(.MAPA_WIDTH(W), .MAPA_HEIGHT(H), .COORD_W(CW), .FIFO_DEPTH(DEPTH))
        dut (.clk(clk), .reset(reset), .bus(bus));

    logic          ch_valid [3];
    logic [CW-1:0] ch_x [3];
    logic [CW-1:0] ch_y [3];
    logic [1:0]    ch_data [3];
    logic          wready, clr;

    assign bus.snake_valid = ch_valid[0];
    assign bus.snake_x = ch_x[0];  assign bus.snake_y = ch_y[0];  assign bus.snake_data = ch_data[0];
    assign bus.fruta_valid = ch_valid[1];
    assign bus.fruta_x = ch_x[1];  assign bus.fruta_y = ch_y[1];  assign bus.fruta_data = ch_data[1];
    assign bus.obst_valid  = ch_valid[2];
    assign bus.obst_x  = ch_x[2];  assign bus.obst_y  = ch_y[2];  assign bus.obst_data  = ch_data[2];
    assign bus.mapa_wready = wready;
    assign bus.clear_start = clr;

    int vectors = 0, miscompares = 0;
    logic [21:0] mq[$];   // every write the map should still receive, in order
    bit  busy;
    int  drops, border_seen, clr_writes;
    bit  acc [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] sweep_ent(input int x, input int y);
        logic [1:0] d;
        d = 2'b00;
`ifdef MAPA_WR_BORDER_EN
        if (x == 0 || x == W-1 || y == 0 || y == H-1) d = 2'b11;
`endif
        return {CW'(x), CW'(y), d};
    endfunction

    task automatic set_req(input int i, input int x, input int y, input logic [1:0] d);
        ch_valid[i] = 1'b1;
        ch_x[i]     = CW'(x);
        ch_y[i]     = CW'(y);
        ch_data[i]  = d;
    endtask

    task automatic rand_req(input int i);
        int x, y;
        x = ($urandom_range(0, 15) == 0) ? int'($urandom_range(W, 63)) : int'($urandom_range(0, W-1));
        y = ($urandom_range(0, 15) == 0) ? int'($urandom_range(H, 40)) : int'($urandom_range(0, H-1));
        set_req(i, x, y, 2'($urandom_range(0, 3)));
    endtask

    task automatic drop_accepted();
        for (int i = 0; i < 3; i++) if (acc[i]) ch_valid[i] = 1'b0;
    endtask

    // Check one cycle at the falling edge, then advance the model across the next rising edge.
    task automatic run_cycle();
        bit [2:0]    rdy;
        bit          pop, was_busy;
        logic [21:0] ent;
        @(negedge clk);
        was_busy = busy;
        rdy[0] = !busy && (mq.size() < DEPTH);
        rdy[1] = rdy[0] && !ch_valid[0];
        rdy[2] = rdy[1] && !ch_valid[1];
        chk("snake_ready", 32'(bus.snake_ready), 32'(rdy[0]));
        chk("fruta_ready", 32'(bus.fruta_ready), 32'(rdy[1]));
        chk("obst_ready",  32'(bus.obst_ready),  32'(rdy[2]));
        chk("clear_busy",  32'(bus.clear_busy),  32'(busy));
        chk("drop_count",  32'(bus.drop_count),  32'(drops));
        if (!busy) begin
            chk("fifo_level",     32'(bus.fifo_level),     32'(mq.size()));
            chk("update_wenable", 32'(bus.update_wenable), 32'(mq.size() != 0));
            pop = (mq.size() != 0) && wready;
        end else begin
            pop = bus.update_wenable && wready;
        end
        if (pop) begin
            if (mq.size() == 0) begin
                chk("write_past_end", 32'(bus.update_wenable), 32'd0);
            end else begin
                ent = mq.pop_front();
                chk("write_head", 32'({bus.update_wx, bus.update_wy, bus.update_wdata}), 32'(ent));
                if (busy) begin
                    clr_writes++;
                    if (bus.update_wdata == 2'b11) border_seen++;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            acc[i] = ch_valid[i] && rdy[i];
            if (acc[i]) begin
                if (ch_x[i] < W && ch_y[i] < H) mq.push_back({ch_x[i], ch_y[i], ch_data[i]});
                else if (drops < 255)           drops++;
            end
        end
        if (was_busy && pop && mq.size() == 0) busy = 1'b0;
        if (clr && !was_busy) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    mq.push_back(sweep_ent(x, y));
            busy = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_quiet(input string tag, input int limit);
        int n;
        n = 0;
        while ((busy || mq.size() != 0 || ch_valid[0] || ch_valid[1] || ch_valid[2]) && n < limit) begin
            run_cycle();
            drop_accepted();
            n++;
        end
        if (n >= limit) chk(tag, 32'(bus.clear_busy | bus.update_wenable), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rdy"},   32'({bus.snake_ready, bus.fruta_ready, bus.obst_ready}), 32'd0);
        chk({tag, "_wen"},   32'(bus.update_wenable), 32'd0);
        chk({tag, "_wpos"},  32'({bus.update_wx, bus.update_wy, bus.update_wdata}), 32'd0);
        chk({tag, "_busy"},  32'(bus.clear_busy), 32'd0);
        chk({tag, "_level"}, 32'(bus.fifo_level), 32'd0);
        chk({tag, "_drops"}, 32'(bus.drop_count), 32'd0);
    endtask

    initial begin
        int sent;
        reset = 1'b0; wready = 1'b0; clr = 1'b0;
        busy = 1'b0; drops = 0; border_seen = 0; clr_writes = 0;
        for (int i = 0; i < 3; i++) begin
            set_req(i, 1, 1, 2'b01);
            acc[i] = 1'b0;
        end
        #3;
        chk_zero_outputs("reset");
        for (int i = 0; i < 3; i++) ch_valid[i] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        // Single write, one-cycle latency
        wready = 1'b1;
        set_req(0, 5, 7, 2'b01);
        run_cycle(); drop_accepted();
        run_cycle(); run_cycle();

        // Three producers at once: priority order
        set_req(0, 1, 1, 2'b01); set_req(1, 2, 2, 2'b10); set_req(2, 3, 3, 2'b11);
        run_until_quiet("prio_timeout", 20);

        // Fill to full with map stalled, then drain
        wready = 1'b0; sent = 0;
        set_req(0, 0, 1, 2'b01);
        for (int c = 0; c < 12; c++) begin
            run_cycle();
            if (acc[0]) begin
                sent++;
                if (sent < 9) set_req(0, sent, sent + 1, 2'b01); else ch_valid[0] = 1'b0;
            end
        end
        chk("full_level", 32'(bus.fifo_level), 32'(DEPTH));
        wready = 1'b1;
        for (int c = 0; c < 30 && (sent < 9 || mq.size() != 0); c++) begin
            run_cycle();
            if (acc[0]) begin
                sent++;
                if (sent < 9) set_req(0, sent, sent + 1, 2'b01); else ch_valid[0] = 1'b0;
            end
        end
        chk("ninth_accepted", 32'(sent), 32'd9);

        // Out-of-range fruit request is acknowledged and dropped
        set_req(1, 40, 0, 2'b10);
        run_cycle(); drop_accepted();
        run_cycle(); run_cycle();

        // Clear with two writes pending and a stalled producer
        wready = 1'b0;
        set_req(0, 3, 4, 2'b01); set_req(1, 6, 8, 2'b10);
        for (int c = 0; c < 3; c++) begin run_cycle(); drop_accepted(); end
        border_seen = 0; clr_writes = 0;
        clr = 1'b1; run_cycle(); clr = 1'b0;
        set_req(0, 7, 7, 2'b01);
        for (int c = 0; c < 5; c++) begin run_cycle(); drop_accepted(); end
        wready = 1'b1;
        run_until_quiet("clear_timeout", 3000);
        chk("clear_writes", 32'(clr_writes), 32'd1202);
        chk("border_cells", 32'(border_seen), 32'(BORDER_EXP));

        // Drop counter saturation
        for (int c = 0; c < 270; c++) begin
            if (!ch_valid[2]) set_req(2, 50, c % 30, 2'b11);
            run_cycle(); drop_accepted();
        end
        ch_valid[2] = 1'b0;
        run_cycle();

        // Reset in the middle of the sweep
        clr = 1'b1; run_cycle(); clr = 1'b0;
        for (int c = 0; c < 300; c++) run_cycle();
        set_req(0, 9, 9, 2'b01);
        #2 reset = 1'b0;
        #1 chk_zero_outputs("mid_reset");
        mq.delete(); busy = 1'b0; drops = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        run_until_quiet("post_reset_timeout", 20);

        // Randomized traffic with occasional clears and map stalls
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < 3; i++)
                if (!ch_valid[i] && $urandom_range(0, 99) < 35) rand_req(i);
            wready = ($urandom_range(0, 99) < 75);
            clr    = ($urandom_range(0, 999) == 0);
            run_cycle();
            clr = 1'b0;
            drop_accepted();
        end
        wready = 1'b1;
        run_until_quiet("final_timeout", 4000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mapa_write_arbiter.md
Name: mapa_write_arbiter

Overview:
- Writer side of the map RAM write port (update_wenable/wx/wy/wdata).
- Merges cell-write requests from three producers (snake, fruit, obstacle) into one ordered stream through a small FIFO.
- Adds a sequenced full-map clear.
- Sits between the game-logic producers and mapa. It is the counterpart to the read path that the renderer drives.

Parameters:
- MAPA_WIDTH, 40, map columns in cells
- MAPA_HEIGHT, 30, map rows in cells
- COORD_W, 10, coordinate width
- FIFO_DEPTH, 8, write-queue entries (power of two)

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-low reset
- snake_valid/snake_ready  in/out  1/1  snake channel handshake
- snake_x, snake_y, snake_data  in  COORD_W, COORD_W, 2  snake cell write
- fruta_valid/fruta_ready  in/out  1/1  fruit channel handshake
- fruta_x, fruta_y, fruta_data  in  COORD_W, COORD_W, 2
- obst_valid/obst_ready  in/out  1/1  obstacle channel handshake
- obst_x, obst_y, obst_data  in  COORD_W, COORD_W, 2
- clear_start  in  1  one-cycle pulse requesting a map clear
- clear_busy  out  1  clear in progress
- mapa_wready  in  1  map port can accept a write this cycle
- update_wenable  out  1  write strobe to mapa
- update_wx, update_wy  out  COORD_W  write cell coordinates
- update_wdata  out  2  cell code
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current queue occupancy
- drop_count  out  8  out-of-range requests discarded (saturating)

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO is emptied and the FSM goes to IDLE.
  - All outputs are 0: readys, update_*, clear_busy, fifo_level, drop_count.
- Handshake:
  - A transfer occurs when valid && ready at a rising edge.
  - Producers hold x, y and data stable while valid is high and ready is low.
- Arbitration:
  - Fixed priority snake > fruta > obst. At most one channel is granted per cycle.
  - x_ready = (state==IDLE) && !full && no higher-priority valid.
  - ready is combinational from registered state and the current valids.
- Range check:
  - A granted request with x >= MAPA_WIDTH or y >= MAPA_HEIGHT is acknowledged (ready=1) but not enqueued.
  - drop_count increments and saturates at 255.
- Output:
  - update_wenable = !empty. update_wx, update_wy and update_wdata show the FIFO head.
  - The head is popped when update_wenable && mapa_wready; otherwise the outputs hold.
  - Latency: a request accepted at edge N is visible at update_* after edge N (cycle N+1) if the FIFO was empty.
  - No input-to-output bypass.
- Full and empty:
  - Push is blocked when full; push and pop in the same cycle are permitted when not full.
  - fifo_level updates after each edge.
- FSM states IDLE, DRAIN, SWEEP, FLUSH:
  - IDLE --clear_start--> DRAIN. clear_busy goes to 1 at the next edge.
  - DRAIN: all readys are 0 and pending FIFO entries are written. When empty, go to SWEEP with cx=cy=0.
  - SWEEP: enqueue (cx,cy,EMPTY) each cycle the FIFO is not full. cx counts up and wraps to 0 at MAPA_WIDTH-1, incrementing cy. After (MAPA_WIDTH-1, MAPA_HEIGHT-1) is enqueued, go to FLUSH.
  - FLUSH: wait for empty, then go to IDLE and clear_busy goes to 0.
  - clear_start outside IDLE is ignored.
  - Producer valids during a clear are stalled, not lost.
- Reset mid-clear: abort immediately and return to reset values. Queued writes are lost.

Optional Feature:
- Macro MAPA_WR_BORDER_EN.
- Defined: during SWEEP, cells with cx==0, cx==MAPA_WIDTH-1, cy==0 or cy==MAPA_HEIGHT-1 are written OBSTACULO (2'b11), giving a walled arena. Interior cells are written EMPTY.
- Undefined: every cell is written EMPTY.

Decomposition:
- Shared package mapa_pkg:
  - cell codes CELL_EMPTY=2'b00, CELL_COBRA=2'b01, CELL_FRUTA=2'b10, CELL_OBSTACULO=2'b11
  - MAPA_WIDTH/MAPA_HEIGHT defaults
  - FSM state enum
- One sub-module: mapa_wr_fifo, a synchronous FIFO (push/pop/full/empty/level) holding {x,y,data}.

Test Plan:
- Reset release, mapa_wready=1, snake (5,7,01): snake_ready=1 same cycle. Next cycle update_wenable=1, wx=5, wy=7, wdata=01. Then update_wenable returns to 0.
- snake (1,1,01), fruta (2,2,10) and obst (3,3,11) all valid together: granted on consecutive cycles. Writes appear in order snake, fruta, obst.
- mapa_wready=0, push 9 snake requests: readys fall after 8 and fifo_level=8. With wready=1, 8 writes drain in order, then the 9th is accepted.
- fruta (40,0,10): fruta_ready=1, no write issued, drop_count=1.
- clear_start with 2 entries queued: those 2 writes first, then 1200 EMPTY writes in raster order. clear_busy falls the cycle after the last pop. With MAPA_WR_BORDER_EN, exactly 136 of them are 2'b11.
- reset=0 midway through SWEEP: all outputs 0 at once, fifo_level=0. After release, IDLE accepts new requests.
